// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end: opcodes, issue classes,
// instruction field layout and the fetch-queue entry format.
package tomasulo_pkg;

  localparam int FQ_DEPTH = 4;
  localparam int INSTR_W  = 16;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_BNE  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [1:0] CLS_ADD = 2'b00;
  localparam logic [1:0] CLS_MUL = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_NOP = 2'b11;

  typedef struct packed {
    logic [3:0] pc;
    logic [3:0] op;
    logic [1:0] cls;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } fq_entry_t;

  function automatic logic [1:0] op_class(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: op_class = CLS_ADD;
      OP_MUL, OP_DIV: op_class = CLS_MUL;
      OP_BEQ, OP_BNE: op_class = CLS_BR;
      default:        op_class = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/fq_decode.sv
// Combinational instruction decoder: splits a fetched word into issue fields
// and flags HALT so the queue can stop fetching.
module fq_decode
  import tomasulo_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output logic [3:0]         op_o,
  output logic [1:0]         cls_o,
  output logic [3:0]         rd_o,
  output logic [3:0]         rs1_o,
  output logic [3:0]         rs2_o,
  output logic               is_halt_o
);

  assign op_o      = instr_i[OP_HI:OP_LO];
  assign rd_o      = instr_i[RD_HI:RD_LO];
  assign rs1_o     = instr_i[RS1_HI:RS1_LO];
  assign rs2_o     = instr_i[RS2_HI:RS2_LO];
  assign cls_o     = op_class(op_o);
  assign is_halt_o = (op_o == OP_HALT);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch unit with a circular issue queue feeding the Tomasulo
// issue stage; supports branch-mispredict flush and HALT stop.
module fetch_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int IW    = INSTR_W
) (
  input  logic          clk1,
  input  logic          rst_n,
  output logic [3:0]    imem_addr,
  input  logic [IW-1:0] imem_data,
  input  logic          flush,
  input  logic [3:0]    redirect_pc,
  output logic          iss_valid,
  input  logic          iss_ready,
  output logic [3:0]    iss_pc,
  output logic [3:0]    iss_op,
  output logic [1:0]    iss_class,
  output logic [3:0]    iss_rd,
  output logic [3:0]    iss_rs1,
  output logic [3:0]    iss_rs2,
  output logic [2:0]    q_count,
  output logic          halted
);

  localparam int         PW       = $clog2(DEPTH);
  localparam logic [2:0] FULL_CNT = 3'(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     head_ent;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [2:0]    count_q, count_d;
  logic [3:0]    pc_q, pc_d;
  logic          halted_q, halted_d;

  logic [3:0] dec_op, dec_rd, dec_rs1, dec_rs2;
  logic [1:0] dec_cls;
  logic       dec_halt;
  logic       pop, fetch, push;

  fq_decode u_decode (
    .instr_i   (imem_data[INSTR_W-1:0]),
    .op_o      (dec_op),
    .cls_o     (dec_cls),
    .rd_o      (dec_rd),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .is_halt_o (dec_halt)
  );

  // A full queue may still fetch when the head leaves in the same cycle.
  assign pop   = (count_q != 3'd0) && iss_ready;
  assign fetch = !halted_q && !flush && ((count_q < FULL_CNT) || pop);
  assign push  = fetch && !dec_halt;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    if (flush) begin
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else begin
      if (pop) head_d = head_q + 1'b1;
      if (push) begin
        tail_d = tail_q + 1'b1;
        pc_d   = pc_q + 4'd1;
      end
      if (fetch && dec_halt) halted_d = 1'b1;
      count_d = count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // Storage is left unreset; only occupied slots are ever presented.
  always_ff @(posedge clk1) begin
    if (push) begin
      mem_q[tail_q] <= '{pc: pc_q, op: dec_op, cls: dec_cls,
                         rd: dec_rd, rs1: dec_rs1, rs2: dec_rs2};
    end
  end

  assign head_ent  = mem_q[head_q];
  assign iss_valid = (count_q != 3'd0);
  assign iss_pc    = iss_valid ? head_ent.pc  : 4'd0;
  assign iss_op    = iss_valid ? head_ent.op  : 4'd0;
  assign iss_class = iss_valid ? head_ent.cls : 2'd0;
  assign iss_rd    = iss_valid ? head_ent.rd  : 4'd0;
  assign iss_rs1   = iss_valid ? head_ent.rs1 : 4'd0;
  assign iss_rs2   = iss_valid ? head_ent.rs2 : 4'd0;
  assign q_count   = count_q;
  assign halted    = halted_q;
  assign imem_addr = pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios with hand-derived expectations,
// then randomized traffic against a queue-based reference model.
module tb_fetch_queue;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        flush = 1'b0;
  logic [3:0]  redirect_pc = 4'd0;
  logic        iss_valid;
  logic        iss_ready = 1'b0;
  logic [3:0]  iss_pc, iss_op, iss_rd, iss_rs1, iss_rs2;
  logic [1:0]  iss_class;
  logic [2:0]  q_count;
  logic        halted;

  logic [15:0] imem [16];
  assign imem_data = imem[imem_addr];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0]  pc;
    logic [15:0] w;
  } ment_t;

  ment_t      m_q[$];
  logic [3:0] m_pc;
  logic       m_halted;

  fetch_queue dut (
    .clk1(clk1), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .flush(flush), .redirect_pc(redirect_pc), .iss_valid(iss_valid),
    .iss_ready(iss_ready), .iss_pc(iss_pc), .iss_op(iss_op), .iss_class(iss_class),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .q_count(q_count),
    .halted(halted)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Assert reset between edges; the next rising edge is the first fetch edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] a;
      a = 4'(i);
      imem[i] = {1'b0, a[2:0], a, ~a, a};
    end
  endtask

  function automatic logic [1:0] cls_of(input logic [3:0] op);
    if (op == 4'h0 || op == 4'h1) return 2'b00;
    if (op == 4'h2 || op == 4'h3) return 2'b01;
    if (op == 4'h4 || op == 4'h5) return 2'b10;
    return 2'b11;
  endfunction

  task automatic model_step();
    logic        pop, fetch;
    logic [15:0] w;
    ment_t       e;
    if (flush) begin
      m_q.delete();
      m_pc = redirect_pc;
      m_halted = 1'b0;
      return;
    end
    pop   = (m_q.size() != 0) && iss_ready;
    fetch = !m_halted && ((m_q.size() < 4) || pop);
    w     = imem[m_pc];
    if (pop) void'(m_q.pop_front());
    if (fetch) begin
      if (w[15:12] == 4'hF) m_halted = 1'b1;
      else begin
        e.pc = m_pc;
        e.w  = w;
        m_q.push_back(e);
        m_pc = m_pc + 4'd1;
      end
    end
  endtask

  task automatic test_reset();
    flush = 0; iss_ready = 1; redirect_pc = 4'd7; rst_n = 0;
    load_default();
    repeat (2) tick();
    n_vec++; if (q_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", q_count); end
    n_vec++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0b want 0", iss_valid); end
    n_vec++; if (imem_addr !== 4'd0) begin n_err++; $display("FAIL rst_addr: got %0d want 0", imem_addr); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %0b want 0", halted); end
    n_vec++; if ({iss_pc, iss_op, iss_class, iss_rd, iss_rs1, iss_rs2} !== 22'd0) begin
      n_err++; $display("FAIL rst_iss_data: got %h want 0", {iss_pc, iss_op, iss_class, iss_rd, iss_rs1, iss_rs2});
    end
  endtask

  task automatic test_first_issue();
    load_default();
    imem[0] = 16'h0312;
    iss_ready = 1; flush = 0;
    do_reset();
    tick();
    n_vec++; if (iss_valid !== 1'b1) begin n_err++; $display("FAIL first_valid: got %0b want 1", iss_valid); end
    n_vec++; if (iss_pc !== 4'd0) begin n_err++; $display("FAIL first_pc: got %0d want 0", iss_pc); end
    n_vec++; if (iss_class !== 2'b00) begin n_err++; $display("FAIL first_class: got %b want 00", iss_class); end
    n_vec++; if ({iss_op, iss_rd, iss_rs1, iss_rs2} !== 16'h0312) begin
      n_err++; $display("FAIL first_fields: got %h want 0312", {iss_op, iss_rd, iss_rs1, iss_rs2});
    end
    n_vec++; if (q_count !== 3'd1) begin n_err++; $display("FAIL first_count: got %0d want 1", q_count); end
  endtask

  task automatic test_saturate();
    load_default();
    iss_ready = 0; flush = 0;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++; if (q_count !== 3'((k < 4) ? k : 4)) begin
        n_err++; $display("FAIL sat_count[%0d]: got %0d want %0d", k, q_count, (k < 4) ? k : 4);
      end
      n_vec++; if (iss_pc !== 4'd0) begin n_err++; $display("FAIL sat_hold_pc[%0d]: got %0d want 0", k, iss_pc); end
    end
    n_vec++; if (imem_addr !== 4'd4) begin n_err++; $display("FAIL sat_addr: got %0d want 4", imem_addr); end
  endtask

  task automatic test_full_flow();
    imem[5] = 16'hF000;
    iss_ready = 1;
    tick();
    n_vec++; if (q_count !== 3'd4) begin n_err++; $display("FAIL full_pp_count: got %0d want 4", q_count); end
    n_vec++; if (imem_addr !== 4'd5) begin n_err++; $display("FAIL full_pp_addr: got %0d want 5", imem_addr); end
    n_vec++; if (iss_pc !== 4'd1) begin n_err++; $display("FAIL full_pp_head: got %0d want 1", iss_pc); end
  endtask

  task automatic test_halt();
    tick();
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_flag: got %0b want 1", halted); end
    n_vec++; if (q_count !== 3'd3) begin n_err++; $display("FAIL halt_count: got %0d want 3", q_count); end
    n_vec++; if (iss_pc !== 4'd2) begin n_err++; $display("FAIL halt_head: got %0d want 2", iss_pc); end
    for (int k = 2; k >= 0; k--) begin
      tick();
      n_vec++; if (q_count !== 3'(k)) begin n_err++; $display("FAIL drain_count: got %0d want %0d", q_count, k); end
    end
    tick();
    n_vec++; if (iss_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %0b want 0", iss_valid); end
    n_vec++; if (imem_addr !== 4'd5) begin n_err++; $display("FAIL halt_addr: got %0d want 5", imem_addr); end
    n_vec++; if ({iss_pc, iss_op, iss_class} !== 10'd0) begin
      n_err++; $display("FAIL drain_data: got %h want 0", {iss_pc, iss_op, iss_class});
    end
  endtask

  task automatic test_flush();
    load_default();
    imem[3] = 16'hF000;
    iss_ready = 0; flush = 0;
    do_reset();
    repeat (4) tick();
    n_vec++; if ({halted, q_count} !== {1'b1, 3'd3}) begin
      n_err++; $display("FAIL pre_flush: got halted=%0b count=%0d want 1/3", halted, q_count);
    end
    flush = 1; redirect_pc = 4'd9; iss_ready = 1;
    tick();
    flush = 0;
    n_vec++; if (q_count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", q_count); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL flush_halted: got %0b want 0", halted); end
    n_vec++; if (imem_addr !== 4'd9) begin n_err++; $display("FAIL flush_addr: got %0d want 9", imem_addr); end
    tick();
    n_vec++; if ({iss_valid, iss_pc, q_count} !== {1'b1, 4'd9, 3'd1}) begin
      n_err++; $display("FAIL post_flush: got valid=%0b pc=%0d count=%0d want 1/9/1", iss_valid, iss_pc, q_count);
    end
  endtask

  task automatic test_wrap_reset();
    int exp_pc [4] = '{14, 15, 0, 1};
    load_default();
    iss_ready = 0; flush = 0;
    do_reset();
    flush = 1; redirect_pc = 4'd14;
    tick();
    flush = 0;
    repeat (4) tick();
    n_vec++; if ({q_count, imem_addr} !== {3'd4, 4'd2}) begin
      n_err++; $display("FAIL wrap_fill: got count=%0d addr=%0d want 4/2", q_count, imem_addr);
    end
    iss_ready = 1;
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (iss_pc !== 4'(exp_pc[k])) begin
        n_err++; $display("FAIL wrap_order[%0d]: got %0d want %0d", k, iss_pc, exp_pc[k]);
      end
      tick();
    end
    rst_n = 0;
    #2;
    n_vec++; if ({q_count, iss_valid, imem_addr, iss_pc} !== 12'd0) begin
      n_err++; $display("FAIL async_rst: got count=%0d valid=%0b addr=%0d pc=%0d want 0", q_count, iss_valid, imem_addr, iss_pc);
    end
    rst_n = 1; iss_ready = 0;
    tick();
    n_vec++; if ({q_count, iss_pc, imem_addr} !== {3'd1, 4'd0, 4'd1}) begin
      n_err++; $display("FAIL restart: got count=%0d pc=%0d addr=%0d want 1/0/1", q_count, iss_pc, imem_addr);
    end
  endtask

  task automatic test_random();
    logic [21:0] exp_bus, got_bus;
    logic [15:0] w;
    for (int i = 0; i < 16; i++) imem[i] = 16'($urandom);
    iss_ready = 0; flush = 0;
    do_reset();
    m_q.delete(); m_pc = 4'd0; m_halted = 1'b0;
    for (int c = 0; c < 800; c++) begin
      iss_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 11) == 0);
      redirect_pc = 4'($urandom);
      if ($urandom_range(0, 7) == 0) imem[$urandom_range(0, 15)] = 16'($urandom);
      if (m_q.size() != 0) begin
        w = m_q[0].w;
        exp_bus = {m_q[0].pc, w[15:12], cls_of(w[15:12]), w[11:8], w[7:4], w[3:0]};
      end else exp_bus = '0;
      got_bus = {iss_pc, iss_op, iss_class, iss_rd, iss_rs1, iss_rs2};
      n_vec++; if ({iss_valid, got_bus} !== {m_q.size() != 0, exp_bus}) begin
        n_err++; $display("FAIL rnd_issue[%0d]: got v=%0b %h want v=%0b %h", c, iss_valid, got_bus, m_q.size() != 0, exp_bus);
      end
      n_vec++; if (q_count !== 3'(m_q.size())) begin
        n_err++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, q_count, m_q.size());
      end
      n_vec++; if ({halted, imem_addr} !== {m_halted, m_pc}) begin
        n_err++; $display("FAIL rnd_pc[%0d]: got h=%0b pc=%0d want h=%0b pc=%0d", c, halted, imem_addr, m_halted, m_pc);
      end
      model_step();
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_first_issue();
    test_saturate();
    test_full_flow();
    test_halt();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two).
REQ-002 Parameter IW, default 16, instruction width.
REQ-003 clk1  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_addr  out  4  instruction memory address; equals the PC register.
REQ-006 imem_data  in  16  instruction word at imem_addr, valid in the same cycle (combinational read).
REQ-007 flush  in  1  branch-mispredict flush from the Tomasulo core.
REQ-008 redirect_pc  in  4  new fetch PC, sampled when flush=1.
REQ-009 iss_valid  out  1  head entry is valid for issue.
REQ-010 iss_ready  in  1  Tomasulo issue stage accepts the head entry this cycle.
REQ-011 iss_pc  out  4  PC of the head entry.
REQ-012 iss_op  out  4  opcode, imem_data[15:12].
REQ-013 iss_class  out  2  00 add-RS, 01 mul-RS, 10 branch-RS, 11 nop.
REQ-014 iss_rd, iss_rs1, iss_rs2  out  4 each  fields [11:8], [7:4], [3:0].
REQ-015 q_count  out  3  number of occupied entries, 0..DEPTH.
REQ-016 halted  out  1  a HALT has been fetched and fetch has stopped.

Function
REQ-017 Opcode decode: 0000 ADD, 0001 SUB -> class 00; 0010 MUL, 0011 DIV -> class 01; 0100 BEQ, 0101 BNE -> class 10; 1111 HALT; all others -> class 11.
REQ-018 Fetch occurs in a cycle when halted=0, flush=0, and (q_count<DEPTH or a pop occurs that cycle).
REQ-019 A fetch of a non-HALT word enqueues {pc, op, class, rd, rs1, rs2} at the tail and sets pc to pc+1 mod 16 (15 wraps to 0).
REQ-020 A fetch of HALT does not enqueue; it sets halted=1 and holds pc.
REQ-021 A pop occurs when iss_valid=1 and iss_ready=1; the head advances by one, wrapping modulo DEPTH.
REQ-022 A simultaneous push and pop leaves q_count unchanged, including at q_count=DEPTH and q_count=0 (a push into an empty queue with iss_ready=1 is not popped that cycle).
REQ-023 iss_valid shall equal (q_count!=0); when q_count=0, all iss_* data outputs shall be 0.
REQ-024 Latency: a word fetched in cycle N is presented on iss_* in cycle N+1 when the queue was empty.
REQ-025 iss_* fields shall stay stable while iss_valid=1 and iss_ready=0.
REQ-026 On flush=1, the block shall, at the next edge, empty the queue, set pc=redirect_pc, and clear halted; fetch and pop in that cycle are discarded.
REQ-027 Flush takes priority over push, pop, and HALT detection in the same cycle.
REQ-028 iss_ready while iss_valid=0 shall have no effect.

Reset
REQ-029 While rst_n=0: pc=0, head=0, tail=0, q_count=0, halted=0, iss_valid=0, imem_addr=0, all iss_* data outputs=0.
REQ-030 Reset asserted mid-operation discards all queue contents immediately (asynchronously); the first fetch after release is from address 0 on the first rising edge with rst_n=1.
REQ-031 Queue storage array need not be reset; only pointers, count, pc, and halted.

Structure
REQ-032 Opcode constants, class encodings, instruction field positions, and DEPTH default live in shared package tomasulo_pkg, also used by the Tomasulo core.
REQ-033 The combinational decoder is a sub-module fq_decode (imem_data -> op, class, rd, rs1, rs2, is_halt); the queue and PC logic live in fetch_queue.

Verification
REQ-034 Reset, then imem = ADD r3,r1,r2 (0x0312) at addr 0, iss_ready=1 -> cycle 1: iss_valid=1, iss_pc=0, iss_class=00, iss_rd=3.
REQ-035 iss_ready=0 for 6 cycles with non-HALT imem -> q_count saturates at 4; imem_addr holds at 4; iss_pc stays 0.
REQ-036 Queue full, then iss_ready=1 -> push and pop in the same cycle; q_count stays 4, pc increments by 1 per cycle.
REQ-037 HALT (0xF000) at addr 5 -> halted=1 after the fetch edge, imem_addr stays 5, queue drains to q_count=0, and iss_valid drops.
REQ-038 flush=1 with redirect_pc=9 while q_count=3 and halted=1 -> next cycle: q_count=0, halted=0, imem_addr=9; following cycle: iss_pc=9.
REQ-039 Fetch running from pc=14 -> addresses 14, 15, 0, 1 are enqueued in order; mid-stream rst_n pulse -> q_count=0 immediately, and fetch restarts at 0.
